// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for the UART subsystem: the 16x baud strobe and
// serial line going in, the frame-complete pulse, data byte and framing error
// coming out.
interface uart_rx_if;
   logic       tick;
   logic       rx;
   logic       rx_done_tick;
   logic [7:0] dout;
   logic       frame_err;

   // Receiver side: consumes tick/rx, produces the frame report.
   modport slave (
      input  tick,
      input  rx,
      output rx_done_tick,
      output dout,
      output frame_err
   );

   // Driver side: produces tick/rx, consumes the frame report.
   modport master (
      output tick,
      output rx,
      input  rx_done_tick,
      input  dout,
      input  frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling. The asynchronous line is brought into
// the clk domain through two flops; the start bit is confirmed at mid-bit,
// data bits are shifted in LSB first at their centres, and the stop bit is
// sampled after SB_TICK_MAX+1 ticks. Each frame ends with a one-cycle
// rx_done_tick alongside the right-aligned byte and a framing-error flag.
module uart_rx #(
   parameter int unsigned DBIT_MAX    = 7,   // data bits minus 1, 4..7
   parameter int unsigned SB_TICK_MAX = 15   // stop-bit ticks minus 1, 15..31
) (
   input logic  clk,
   input logic  reset_n,
   uart_rx_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic [4:0] MID_START = 5'd7;
   localparam logic [4:0] BIT_END   = 5'd15;
   localparam logic [4:0] STOP_END  = 5'(SB_TICK_MAX);
   localparam logic [2:0] LAST_BIT  = 3'(DBIT_MAX);

   // Bits enter at the MSB, so a short word ends up in the top of the
   // register; shift it down so the byte is right-aligned with zero fill.
   function automatic logic [7:0] align_dout(input logic [7:0] sr);
      return sr >> (7 - DBIT_MAX);
   endfunction

   logic       rx_meta;
   logic       rx_s;
   state_t     state;
   logic [4:0] s_cnt;
   logic [2:0] n_cnt;
   logic [7:0] b_reg;
   logic       done_q;
   logic [7:0] dout_q;
   logic       ferr_q;

   // Two-flop synchroniser, reset to the idle-high line level so a reset
   // release never looks like a start edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM with counters, shift register and registered frame report.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         s_cnt  <= 5'd0;
         n_cnt  <= 3'd0;
         b_reg  <= 8'd0;
         done_q <= 1'b0;
         dout_q <= 8'd0;
         ferr_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            // Start detection is clk-accurate; no tick is needed here.
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s_cnt <= 5'd0;
               end
            end
            // Confirm the start bit at its centre; a high line there is a glitch.
            START: begin
               if (bus.tick) begin
                  if (s_cnt == MID_START) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s_cnt <= 5'd0;
                        n_cnt <= 3'd0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end
            // Sample each data bit one full bit time after the previous centre.
            DATA: begin
               if (bus.tick) begin
                  if (s_cnt == BIT_END) begin
                     s_cnt <= 5'd0;
                     b_reg <= {rx_s, b_reg[7:1]};
                     if (n_cnt == LAST_BIT) begin
                        state <= STOP;
                     end else begin
                        n_cnt <= n_cnt + 3'd1;
                     end
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end
            // Sample the stop bit and report the frame even when it is low,
            // returning to idle so an immediately following start is caught.
            STOP: begin
               if (bus.tick) begin
                  if (s_cnt == STOP_END) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                     dout_q <= align_dout(b_reg);
                     ferr_q <= ~rx_s;
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rx_done_tick = done_q;
   assign bus.dout         = dout_q;
   assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (8N1, 8 data + 2 stop, 7N1) share one
// tick generator; the bench serialises frames onto each line and checks the
// reported frames against the byte that was sent.
`timescale 1ns/1ps
module tb_uart_rx;

   typedef struct {
      logic [7:0]  dout;
      logic        fe;
      int unsigned cyc;
   } rec_t;

   typedef struct {
      string      name;
      logic [7:0] data;
      logic       stop_val;
      logic [7:0] exp_dout;
      logic       exp_fe;
   } vec_t;

   logic clk;
   logic reset_n;
   logic tick;
   logic rx0, rx1, rx2;
   int   tick_div;
   int unsigned cyc;
   int unsigned start_cyc;
   int   pass_cnt;
   int   total_cnt;
   int   wide0, wide1, wide2;
   logic prev0, prev1, prev2;
   rec_t q0[$], q1[$], q2[$];

   uart_rx_if bus0 ();
   uart_rx_if bus1 ();
   uart_rx_if bus2 ();

   assign bus0.tick = tick;
   assign bus1.tick = tick;
   assign bus2.tick = tick;
   assign bus0.rx   = rx0;
   assign bus1.rx   = rx1;
   assign bus2.rx   = rx2;

   uart_rx #(.DBIT_MAX(7), .SB_TICK_MAX(15)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
   uart_rx #(.DBIT_MAX(7), .SB_TICK_MAX(31)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
   uart_rx #(.DBIT_MAX(6), .SB_TICK_MAX(15)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One-clk tick every tick_div clocks, changed on the falling edge.
   initial begin
      tick = 1'b0;
      forever begin
         repeat (tick_div - 1) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   // Frame monitors: log every rising rx_done_tick, count over-long pulses.
   always @(negedge clk) begin
      if (bus0.rx_done_tick) begin
         if (prev0) wide0 <= wide0 + 1;
         else q0.push_back('{bus0.dout, bus0.frame_err, cyc});
      end
      prev0 <= bus0.rx_done_tick;
   end
   always @(negedge clk) begin
      if (bus1.rx_done_tick) begin
         if (prev1) wide1 <= wide1 + 1;
         else q1.push_back('{bus1.dout, bus1.frame_err, cyc});
      end
      prev1 <= bus1.rx_done_tick;
   end
   always @(negedge clk) begin
      if (bus2.rx_done_tick) begin
         if (prev2) wide2 <= wide2 + 1;
         else q2.push_back('{bus2.dout, bus2.frame_err, cyc});
      end
      prev2 <= bus2.rx_done_tick;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "time limit");
   end

   // Expected byte of a frame: the low nbits of what was sent.
   function automatic logic [7:0] model_byte(input logic [7:0] d, input int nbits);
      int v;
      v = int'(d) % (1 << nbits);
      return 8'(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      total_cnt++;
      if (act >= lo && act <= hi) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   function automatic int qsize(input int sel);
      case (sel)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic pop_cmp(input int sel, input string name, input logic [7:0] ed, input logic ef,
                          output int unsigned rcyc);
      rec_t r;
      r.dout = 8'hxx;
      r.fe   = 1'bx;
      r.cyc  = 0;
      case (sel)
         0:       if (q0.size() > 0) r = q0.pop_front();
         1:       if (q1.size() > 0) r = q1.pop_front();
         default: if (q2.size() > 0) r = q2.pop_front();
      endcase
      chk({name, " dout"}, {24'd0, r.dout}, {24'd0, ed});
      chk({name, " frame_err"}, {31'd0, r.fe}, {31'd0, ef});
      rcyc = r.cyc;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (tick !== 1'b1) @(posedge clk);
      end
   endtask

   task automatic set_rx(input int sel, input logic v);
      @(negedge clk);
      case (sel)
         0:       rx0 = v;
         1:       rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   // Serialise one frame: start, nbits LSB first, then the stop level held
   // a little past the receiver's stop sample point before idling high.
   task automatic send_frame(input int sel, input logic [7:0] d, input int nbits,
                             input int stop_ticks, input logic stop_val);
      set_rx(sel, 1'b0);
      start_cyc = cyc;
      wait_ticks(16);
      for (int i = 0; i < nbits; i++) begin
         set_rx(sel, d[i]);
         wait_ticks(16);
      end
      set_rx(sel, stop_val);
      wait_ticks(stop_ticks - 6);
      set_rx(sel, 1'b1);
      wait_ticks(6);
   endtask

   vec_t        vecs[3];
   int unsigned rc;
   logic [7:0]  rd;
   logic        sv;

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      wide0 = 0; wide1 = 0; wide2 = 0;
      prev0 = 0; prev1 = 0; prev2 = 0;
      cyc = 0;
      start_cyc = 0;
      tick_div = 16;
      rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
      reset_n = 1'b0;

      vecs[0] = '{"good 0x3C", 8'h3C, 1'b1, 8'h3C, 1'b0};
      vecs[1] = '{"ferr 0x5A", 8'h5A, 1'b0, 8'h5A, 1'b1};
      vecs[2] = '{"good 0x01", 8'h01, 1'b1, 8'h01, 1'b0};

      repeat (3) @(negedge clk);
      #1;
      chk("reset done0", {31'd0, bus0.rx_done_tick}, 32'd0);
      chk("reset dout0", {24'd0, bus0.dout}, 32'd0);
      chk("reset ferr0", {31'd0, bus0.frame_err}, 32'd0);
      chk("reset dout1", {24'd0, bus1.dout}, 32'd0);
      chk("reset dout2", {24'd0, bus2.dout}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_ticks(4);

      // Single byte with latency to the done pulse.
      send_frame(0, 8'hA5, 8, 16, 1'b1);
      chk("A5 count", 32'(qsize(0)), 32'd1);
      pop_cmp(0, "A5", 8'hA5, 1'b0, rc);
      chk_range("A5 latency", int'(rc - start_cyc), 2420, 2460);
      wait_ticks(24);

      // Short low pulse must be rejected.
      set_rx(0, 1'b0);
      wait_ticks(3);
      set_rx(0, 1'b1);
      wait_ticks(20);
      chk("glitch count", 32'(qsize(0)), 32'd0);

      for (int i = 0; i < 3; i++) begin
         send_frame(0, vecs[i].data, 8, 16, vecs[i].stop_val);
         chk({vecs[i].name, " count"}, 32'(qsize(0)), 32'd1);
         pop_cmp(0, vecs[i].name, vecs[i].exp_dout, vecs[i].exp_fe, rc);
         wait_ticks(24);
      end

      // Back-to-back frames, one and two stop bits.
      send_frame(0, 8'h00, 8, 16, 1'b1);
      send_frame(0, 8'hFF, 8, 16, 1'b1);
      chk("b2b count", 32'(qsize(0)), 32'd2);
      pop_cmp(0, "b2b first", 8'h00, 1'b0, rc);
      pop_cmp(0, "b2b second", 8'hFF, 1'b0, rc);
      send_frame(1, 8'h00, 8, 32, 1'b1);
      send_frame(1, 8'hFF, 8, 32, 1'b1);
      chk("b2b sb2 count", 32'(qsize(1)), 32'd2);
      pop_cmp(1, "b2b sb2 first", 8'h00, 1'b0, rc);
      pop_cmp(1, "b2b sb2 second", 8'hFF, 1'b0, rc);
      wait_ticks(24);

      // Reset during data bit 4 of 0x81.
      rd = 8'h81;
      set_rx(0, 1'b0);
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         set_rx(0, rd[i]);
         wait_ticks(16);
      end
      set_rx(0, rd[4]);
      wait_ticks(8);
      @(negedge clk);
      reset_n = 1'b0;
      rx0 = 1'b1;
      #1;
      chk("midreset dout", {24'd0, bus0.dout}, 32'd0);
      chk("midreset done", {31'd0, bus0.rx_done_tick}, 32'd0);
      chk("midreset ferr", {31'd0, bus0.frame_err}, 32'd0);
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      wait_ticks(30);
      chk("midreset no pulse", 32'(qsize(0)), 32'd0);
      send_frame(0, 8'h81, 8, 16, 1'b1);
      chk("after reset count", 32'(qsize(0)), 32'd1);
      pop_cmp(0, "after reset", 8'h81, 1'b0, rc);
      wait_ticks(40);
      chk("dout hold", {24'd0, bus0.dout}, 32'h81);

      // Randomised frames against the byte model, faster tick.
      tick_div = 4;
      wait_ticks(4);
      for (int i = 0; i < 16; i++) begin
         rd = 8'($urandom);
         sv = ($urandom_range(0, 3) != 0);
         send_frame(0, rd, 8, 16, sv);
         chk("rand8 count", 32'(qsize(0)), 32'd1);
         pop_cmp(0, "rand8", model_byte(rd, 8), ~sv, rc);
         wait_ticks($urandom_range(2, 5));
      end
      for (int i = 0; i < 16; i++) begin
         rd = 8'($urandom);
         send_frame(2, rd, 7, 16, 1'b1);
         chk("rand7 count", 32'(qsize(2)), 32'd1);
         pop_cmp(2, "rand7", model_byte(rd, 7), 1'b0, rc);
         wait_ticks($urandom_range(0, 3));
      end

      wait_ticks(8);
      chk("pulse width", 32'(wide0 + wide1 + wide2), 32'd0);
      chk("stray dut1 frames", 32'(qsize(1)), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
